// File: rtl/clb_ccff_bank.sv
// Configuration-memory bank for CLB/routing tiles.
// NUM_CHAINS independent serial shift chains of CHAIN_LEN bits, loaded on prog_clk.
// A completed session commits the chain into a shadow register that drives the
// fabric, so partially shifted configuration is never visible on mem_out.
// Sessions can also rotate the chain for non-destructive readback via ccff_tail.
module clb_ccff_bank #(
    parameter int unsigned CHAIN_LEN  = 64,
    parameter int unsigned NUM_CHAINS = 2,
    parameter int unsigned CNT_W      = $clog2(CHAIN_LEN + 1)
) (
    input  logic                             prog_clk,
    input  logic                             pReset,
    input  logic                             config_enable,
    input  logic                             readback_en,
    input  logic                             Test_en,
    input  logic [NUM_CHAINS-1:0]            ccff_head,
    output logic [NUM_CHAINS-1:0]            ccff_tail,
    output logic [NUM_CHAINS*CHAIN_LEN-1:0]  mem_out,
    output logic [NUM_CHAINS*CHAIN_LEN-1:0]  mem_outb,
    output logic [CNT_W-1:0]                 shift_count,
    output logic                             config_done,
    output logic                             config_err
);

    localparam int unsigned     MemW    = NUM_CHAINS * CHAIN_LEN;
    localparam logic [CNT_W-1:0] FullCnt = CNT_W'(CHAIN_LEN);
    localparam logic [CNT_W-1:0] OneCnt  = CNT_W'(1);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StCommit
    } state_e;

    state_e            state_q, state_d;
    logic              mode_q, mode_d;      // 1 = rotate (readback), 0 = load
    logic [MemW-1:0]   chain_q, chain_d;
    logic [MemW-1:0]   shadow_q, shadow_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              session_entry;
    logic              in_commit;
    logic              count_full;

    // Session sequencing: IDLE -> LOAD -> COMMIT -> IDLE, or COMMIT -> LOAD back-to-back.
    always_comb begin
        state_d       = state_q;
        session_entry = 1'b0;
        case (state_q)
            StIdle: begin
                if (config_enable) begin
                    state_d       = StLoad;
                    session_entry = 1'b1;
                end
            end
            StLoad: begin
                if (!config_enable) begin
                    state_d = StCommit;
                end
            end
            StCommit: begin
                if (config_enable) begin
                    state_d       = StLoad;
                    session_entry = 1'b1;
                end else begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign in_commit  = (state_q == StCommit);
    assign count_full = (count_q == FullCnt);

    // Mode is latched only at session entry; the entry edge already shifts in the new mode.
    always_comb begin
        mode_d = mode_q;
        if (session_entry) begin
            mode_d = readback_en;
        end
    end

    // Chain shift: bit0 takes ccff_head (load) or the chain's own MSB (rotate).
    always_comb begin
        chain_d = chain_q;
        if (config_enable) begin
            for (int c = 0; c < int'(NUM_CHAINS); c++) begin
                chain_d[c*CHAIN_LEN +: CHAIN_LEN] = {
                    chain_q[c*CHAIN_LEN +: (CHAIN_LEN - 1)],
                    (mode_d ? chain_q[c*CHAIN_LEN + CHAIN_LEN - 1] : ccff_head[c])
                };
            end
        end
    end

    // Saturating shift counter, restarted at 1 because entry already shifts once.
    always_comb begin
        count_d = count_q;
        if (session_entry) begin
            count_d = OneCnt;
        end else if (config_enable && !count_full) begin
            count_d = count_q + OneCnt;
        end
    end

    // Commit: only a complete load-mode session updates the shadow; rotate keeps it.
    always_comb begin
        shadow_d = shadow_q;
        if (in_commit && count_full && !mode_q) begin
            shadow_d = chain_q;
        end
    end

    // Status: set by the commit, cleared by entry. On a back-to-back edge the
    // shadow still commits, but the new session's entry clears the flags.
    always_comb begin
        done_d = done_q;
        err_d  = err_q;
        if (in_commit) begin
            if (count_full) begin
                done_d = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end
        if (session_entry) begin
            done_d = 1'b0;
            err_d  = 1'b0;
        end
    end

    // State registers, all cleared asynchronously so a mid-session reset never commits.
    always_ff @(posedge prog_clk or negedge pReset) begin
        if (!pReset) begin
            state_q  <= StIdle;
            mode_q   <= 1'b0;
            chain_q  <= '0;
            shadow_q <= '0;
            count_q  <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            chain_q  <= chain_d;
            shadow_q <= shadow_d;
            count_q  <= count_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    // Serial outputs come straight from each chain's MSB.
    always_comb begin
        ccff_tail = '0;
        for (int c = 0; c < int'(NUM_CHAINS); c++) begin
            ccff_tail[c] = chain_q[c*CHAIN_LEN + CHAIN_LEN - 1];
        end
    end

    // Fabric view: Test_en exposes the live chain, otherwise the committed shadow.
    always_comb begin
        mem_out     = Test_en ? chain_q : shadow_q;
        mem_outb    = ~mem_out;
        shift_count = count_q;
        config_done = done_q;
        config_err  = err_q;
    end

endmodule

// File: tb/tb_clb_ccff_bank.sv
// Directed self-checking bench for clb_ccff_bank.
// Main instance: CHAIN_LEN=8, NUM_CHAINS=2. Second instance: CHAIN_LEN=2, NUM_CHAINS=1.
module tb_clb_ccff_bank;

    logic        prog_clk = 1'b0;
    logic        pReset;
    logic        config_enable;
    logic        readback_en;
    logic        Test_en;
    logic [1:0]  ccff_head;
    logic [1:0]  ccff_tail;
    logic [15:0] mem_out;
    logic [15:0] mem_outb;
    logic [3:0]  shift_count;
    logic        config_done;
    logic        config_err;

    logic        s_cfg_en;
    logic        s_rb_en;
    logic        s_test_en;
    logic [0:0]  s_head;
    logic [0:0]  s_tail;
    logic [1:0]  s_mem_out;
    logic [1:0]  s_mem_outb;
    logic [1:0]  s_count;
    logic        s_done;
    logic        s_err;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 prog_clk = ~prog_clk;

    clb_ccff_bank #(
        .CHAIN_LEN  (8),
        .NUM_CHAINS (2)
    ) u_dut (
        .prog_clk      (prog_clk),
        .pReset        (pReset),
        .config_enable (config_enable),
        .readback_en   (readback_en),
        .Test_en       (Test_en),
        .ccff_head     (ccff_head),
        .ccff_tail     (ccff_tail),
        .mem_out       (mem_out),
        .mem_outb      (mem_outb),
        .shift_count   (shift_count),
        .config_done   (config_done),
        .config_err    (config_err)
    );

    clb_ccff_bank #(
        .CHAIN_LEN  (2),
        .NUM_CHAINS (1)
    ) u_small (
        .prog_clk      (prog_clk),
        .pReset        (pReset),
        .config_enable (s_cfg_en),
        .readback_en   (s_rb_en),
        .Test_en       (s_test_en),
        .ccff_head     (s_head),
        .ccff_tail     (s_tail),
        .mem_out       (s_mem_out),
        .mem_outb      (s_mem_outb),
        .shift_count   (s_count),
        .config_done   (s_done),
        .config_err    (s_err)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge prog_clk);
        #1;
    endtask

    task automatic shift2(input logic [1:0] head);
        config_enable = 1'b1;
        ccff_head     = head;
        tick();
    endtask

    // First bit sent is bit7 of each byte, so the byte lands as written.
    task automatic load_bytes(input logic [7:0] c0, input logic [7:0] c1);
        for (int i = 7; i >= 0; i--) begin
            shift2({c1[i], c0[i]});
        end
    endtask

    task automatic end_session();
        config_enable = 1'b0;
        tick();
        tick();
    endtask

    task automatic s_shift(input logic b);
        s_cfg_en  = 1'b1;
        s_head[0] = b;
        tick();
    endtask

    initial begin
        logic [7:0] rb_seq;
        rb_seq        = 8'hB2;
        pReset        = 1'b0;
        config_enable = 1'b0;
        readback_en   = 1'b0;
        Test_en       = 1'b0;
        ccff_head     = 2'b00;
        s_cfg_en      = 1'b0;
        s_rb_en       = 1'b0;
        s_test_en     = 1'b0;
        s_head        = 1'b0;
        tick();
        tick();

        // Reset state
        check_eq("rst_mem_out", 64'(mem_out), 64'h0000);
        check_eq("rst_mem_outb", 64'(mem_outb), 64'hFFFF);
        check_eq("rst_count", 64'(shift_count), 64'd0);
        check_eq("rst_done", 64'(config_done), 64'd0);
        check_eq("rst_err", 64'(config_err), 64'd0);
        check_eq("rst_tail", 64'(ccff_tail), 64'd0);
        pReset = 1'b1;
        tick();

        // Full load: chain0 = B2, chain1 = FF
        shift2(2'b11);
        check_eq("load_count_first", 64'(shift_count), 64'd1);
        for (int i = 6; i >= 0; i--) begin
            shift2({1'b1, rb_seq[i]});
        end
        check_eq("load_count_8", 64'(shift_count), 64'd8);
        check_eq("load_mem_hold", 64'(mem_out), 64'h0000);
        config_enable = 1'b0;
        tick();
        check_eq("commit_cycle_mem_hold", 64'(mem_out), 64'h0000);
        check_eq("commit_cycle_done", 64'(config_done), 64'd0);
        tick();
        check_eq("full_mem_out", 64'(mem_out), 64'hFFB2);
        check_eq("full_mem_outb", 64'(mem_outb), 64'h004D);
        check_eq("full_done", 64'(config_done), 64'd1);
        check_eq("full_err", 64'(config_err), 64'd0);
        check_eq("full_count", 64'(shift_count), 64'd8);

        // Readback: rotate, head ignored, readback_en dropped mid-session
        readback_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check_eq($sformatf("rb_tail_%0d", i), 64'(ccff_tail), 64'({1'b1, rb_seq[7-i]}));
            shift2(2'b00);
            readback_en = 1'b0;
        end
        end_session();
        check_eq("rb_done", 64'(config_done), 64'd1);
        check_eq("rb_mem_out", 64'(mem_out), 64'hFFB2);
        Test_en = 1'b1;
        #1;
        check_eq("rb_chain_restored", 64'(mem_out), 64'hFFB2);
        Test_en = 1'b0;

        // Short load: 5 zeros
        for (int i = 0; i < 5; i++) begin
            shift2(2'b00);
        end
        end_session();
        check_eq("short_count", 64'(shift_count), 64'd5);
        check_eq("short_err", 64'(config_err), 64'd1);
        check_eq("short_done", 64'(config_done), 64'd0);
        check_eq("short_mem_out", 64'(mem_out), 64'hFFB2);
        check_eq("short_tail", 64'(ccff_tail), 64'b10);
        Test_en = 1'b1;
        #1;
        check_eq("short_test_view", 64'(mem_out), 64'hE040);
        check_eq("short_test_viewb", 64'(mem_outb), 64'h1FBF);
        Test_en = 1'b0;

        // Back-to-back: A = 5A/3C, B = C3/0F, re-enable on the COMMIT edge
        load_bytes(8'h5A, 8'h3C);
        config_enable = 1'b0;
        tick();
        shift2(2'b01);
        check_eq("b2b_first_commit", 64'(mem_out), 64'h3C5A);
        check_eq("b2b_count_restart", 64'(shift_count), 64'd1);
        for (int i = 6; i >= 0; i--) begin
            shift2({8'h0F >> i & 8'h01 ? 1'b1 : 1'b0, 8'hC3 >> i & 8'h01 ? 1'b1 : 1'b0});
        end
        end_session();
        check_eq("b2b_second_commit", 64'(mem_out), 64'h0FC3);
        check_eq("b2b_done", 64'(config_done), 64'd1);
        check_eq("b2b_count", 64'(shift_count), 64'd8);

        // Reset mid-load after 4 shifts
        for (int i = 0; i < 4; i++) begin
            shift2(2'b11);
        end
        check_eq("mid_count_4", 64'(shift_count), 64'd4);
        pReset = 1'b0;
        #1;
        check_eq("mid_rst_mem_out", 64'(mem_out), 64'h0000);
        check_eq("mid_rst_mem_outb", 64'(mem_outb), 64'hFFFF);
        check_eq("mid_rst_count", 64'(shift_count), 64'd0);
        check_eq("mid_rst_done", 64'(config_done), 64'd0);
        check_eq("mid_rst_tail", 64'(ccff_tail), 64'd0);
        Test_en = 1'b1;
        #1;
        check_eq("mid_rst_chain", 64'(mem_out), 64'h0000);
        Test_en       = 1'b0;
        config_enable = 1'b0;
        tick();
        pReset = 1'b1;
        tick();
        check_eq("mid_idle_count", 64'(shift_count), 64'd0);
        check_eq("mid_idle_mem", 64'(mem_out), 64'h0000);
        load_bytes(8'hB2, 8'hFF);
        end_session();
        check_eq("post_rst_mem_out", 64'(mem_out), 64'hFFB2);
        check_eq("post_rst_done", 64'(config_done), 64'd1);

        // Small instance: 2-shift load, then a 3-shift saturating load
        s_shift(1'b1);
        s_shift(1'b1);
        check_eq("s_count_2", 64'(s_count), 64'd2);
        s_cfg_en = 1'b0;
        tick();
        tick();
        check_eq("s_mem_11", 64'(s_mem_out), 64'b11);
        check_eq("s_done_1", 64'(s_done), 64'd1);
        s_shift(1'b1);
        s_shift(1'b0);
        s_shift(1'b1);
        check_eq("s_count_sat", 64'(s_count), 64'd2);
        s_cfg_en = 1'b0;
        tick();
        tick();
        check_eq("s_mem_01", 64'(s_mem_out), 64'b01);
        check_eq("s_mem_outb", 64'(s_mem_outb), 64'b10);
        check_eq("s_done_2", 64'(s_done), 64'd1);
        check_eq("s_err", 64'(s_err), 64'd0);
        check_eq("s_tail", 64'(s_tail), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
